// File: rtl/cache_control.sv
// -----------------------------------------------------------------------------
// cache_control
// Controller for a 2-way, 8-index, 16-byte-line L1 cache. Sits between the CPU
// memory port and physical memory and steers the tag/data array datapath.
// Address split: offset [3:0], index [6:4], tag [15:7].
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   mem_*                   CPU port (request held until mem_resp)
//   set_{one,two}_*         per-way status and stored line from the datapath
//   load_set_*, write_type_set_*, input_data
//                           way load strobes, dirty-on-write select, line to store
//   pmem_*                  physical memory port (request held until pmem_resp)
//
// All outputs are decoded combinationally from the state register and inputs;
// state, per-index LRU bits and the latched miss victim are registered.
// -----------------------------------------------------------------------------
module cache_control (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic         mem_resp,
    input  logic         set_one_hit,
    input  logic         set_two_hit,
    input  logic         set_one_valid,
    input  logic         set_two_valid,
    input  logic         set_one_dirty,
    input  logic         set_two_dirty,
    input  logic [8:0]   set_one_tag,
    input  logic [8:0]   set_two_tag,
    input  logic [127:0] out_data_set_one_f,
    input  logic [127:0] out_data_set_two_f,
    output logic         load_set_one,
    output logic         load_set_two,
    output logic         write_type_set_one,
    output logic         write_type_set_two,
    output logic [127:0] input_data,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t     state_r;
    logic [7:0] lru_r;      // per index: 0 = way one is victim, 1 = way two
    logic       victim_r;   // way chosen at miss time: 0 = one, 1 = two

    logic [2:0]   index_s;
    logic         req_s;
    logic         hit_s;
    logic         hit_way_s;
    logic [127:0] hit_line_s;
    logic         victim_sel_s;
    logic         victim_sel_dirty_s;
    logic [8:0]   victim_tag_s;
    logic [127:0] victim_line_s;
    logic         unused_ok_s;

    // Merge a CPU halfword into a line: word selects the 16-bit slot, be the bytes.
    function automatic logic [127:0] merge_line(input logic [127:0] line,
                                                input logic [2:0]   word,
                                                input logic [1:0]   be,
                                                input logic [15:0]  wdata);
        logic [127:0] result;
        result = line;
        for (int k = 0; k < 8; k++) begin
            result[16*k +: 8]   = ((word == 3'(k)) && be[0]) ? wdata[7:0]  : line[16*k +: 8];
            result[16*k+8 +: 8] = ((word == 3'(k)) && be[1]) ? wdata[15:8] : line[16*k+8 +: 8];
        end
        return result;
    endfunction

    assign index_s     = mem_address[6:4];
    assign req_s       = mem_read | mem_write;
    assign hit_s       = set_one_hit | set_two_hit;
    // Way one wins if both ever report a hit.
    assign hit_way_s   = ~set_one_hit;
    assign hit_line_s  = hit_way_s ? out_data_set_two_f : out_data_set_one_f;
    assign unused_ok_s = mem_address[0];

    // Miss victim: first invalid way, else the LRU choice for this index.
    always_comb begin
        victim_sel_s = 1'b0;
        if (!set_one_valid) begin
            victim_sel_s = 1'b0;
        end else if (!set_two_valid) begin
            victim_sel_s = 1'b1;
        end else begin
            victim_sel_s = lru_r[index_s];
        end
    end

    assign victim_sel_dirty_s = victim_sel_s ? (set_two_valid & set_two_dirty)
                                             : (set_one_valid & set_one_dirty);
    // During writeback the datapath still shows the victim at the current index.
    assign victim_tag_s  = victim_r ? set_two_tag : set_one_tag;
    assign victim_line_s = victim_r ? out_data_set_two_f : out_data_set_one_f;

    // State, LRU and victim registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            lru_r    <= 8'h00;
            victim_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s && hit_s) begin
                        lru_r[index_s] <= ~hit_way_s;
                    end else if (req_s) begin
                        victim_r <= victim_sel_s;
                        state_r  <= victim_sel_dirty_s ? WRITEBACK : FILL;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state_r <= FILL;
                    end else begin
                        state_r <= WRITEBACK;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= FILL;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output decode from state and current inputs.
    always_comb begin
        mem_resp           = 1'b0;
        load_set_one       = 1'b0;
        load_set_two       = 1'b0;
        write_type_set_one = 1'b0;
        write_type_set_two = 1'b0;
        input_data         = 128'h0;
        pmem_address       = 16'h0000;
        pmem_read          = 1'b0;
        pmem_write         = 1'b0;
        pmem_wdata         = 128'h0;
        case (state_r)
            IDLE: begin
                if (req_s && hit_s) begin
                    mem_resp = 1'b1;
                    // A simultaneous read and write is handled as a write.
                    if (mem_write) begin
                        load_set_one       = ~hit_way_s;
                        load_set_two       = hit_way_s;
                        write_type_set_one = ~hit_way_s;
                        write_type_set_two = hit_way_s;
                        input_data = merge_line(hit_line_s, mem_address[3:1],
                                                mem_byte_enable, mem_wdata);
                    end else begin
                        input_data = 128'h0;
                    end
                end else begin
                    mem_resp = 1'b0;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {victim_tag_s, index_s, 4'h0};
                pmem_wdata   = victim_line_s;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[15:4], 4'h0};
                if (pmem_resp) begin
                    load_set_one = ~victim_r;
                    load_set_two = victim_r;
                    input_data   = pmem_rdata;
                end else begin
                    input_data = 128'h0;
                end
            end
            default: begin
                mem_resp = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_control.sv
// -----------------------------------------------------------------------------
// tb_cache_control
// Bench for cache_control. Includes a simple tag/data array that reacts to the
// controller's loads, a physical memory responder with random latency, and a
// reference cache model (arrays of ways plus LRU bits) that predicts every
// writeback, fill, load and response.
// -----------------------------------------------------------------------------
module tb_cache_control;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  mem_address;
    logic         mem_read, mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic         mem_resp;
    logic         set_one_hit, set_two_hit, set_one_valid, set_two_valid;
    logic         set_one_dirty, set_two_dirty;
    logic [8:0]   set_one_tag, set_two_tag;
    logic [127:0] out_data_set_one_f, out_data_set_two_f;
    logic         load_set_one, load_set_two, write_type_set_one, write_type_set_two;
    logic [127:0] input_data;
    logic [15:0]  pmem_address;
    logic         pmem_read, pmem_write;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    cache_control dut (
        .clk(clk), .reset(reset),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
        .set_one_hit(set_one_hit), .set_two_hit(set_two_hit),
        .set_one_valid(set_one_valid), .set_two_valid(set_two_valid),
        .set_one_dirty(set_one_dirty), .set_two_dirty(set_two_dirty),
        .set_one_tag(set_one_tag), .set_two_tag(set_two_tag),
        .out_data_set_one_f(out_data_set_one_f), .out_data_set_two_f(out_data_set_two_f),
        .load_set_one(load_set_one), .load_set_two(load_set_two),
        .write_type_set_one(write_type_set_one), .write_type_set_two(write_type_set_two),
        .input_data(input_data), .pmem_address(pmem_address),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    // ---------------- tag/data array driven by the controller ----------------
    logic         dp_valid [2][8];
    logic         dp_dirty [2][8];
    logic [8:0]   dp_tag   [2][8];
    logic [127:0] dp_data  [2][8];
    logic [2:0]   dp_idx;

    assign dp_idx             = mem_address[6:4];
    assign set_one_valid      = dp_valid[0][dp_idx];
    assign set_two_valid      = dp_valid[1][dp_idx];
    assign set_one_dirty      = dp_dirty[0][dp_idx];
    assign set_two_dirty      = dp_dirty[1][dp_idx];
    assign set_one_tag        = dp_tag[0][dp_idx];
    assign set_two_tag        = dp_tag[1][dp_idx];
    assign out_data_set_one_f = dp_data[0][dp_idx];
    assign out_data_set_two_f = dp_data[1][dp_idx];
    assign set_one_hit        = dp_valid[0][dp_idx] && (dp_tag[0][dp_idx] == mem_address[15:7]);
    assign set_two_hit        = dp_valid[1][dp_idx] && (dp_tag[1][dp_idx] == mem_address[15:7]);

    // Array update on loads; cleared together with the controller.
    always @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < 2; w++) begin
                for (int i = 0; i < 8; i++) begin
                    dp_valid[w][i] <= 1'b0;
                    dp_dirty[w][i] <= 1'b0;
                    dp_tag[w][i]   <= 9'h000;
                    dp_data[w][i]  <= 128'h0;
                end
            end
        end else begin
            if (load_set_one) begin
                dp_valid[0][dp_idx] <= 1'b1;
                dp_dirty[0][dp_idx] <= write_type_set_one;
                dp_tag[0][dp_idx]   <= mem_address[15:7];
                dp_data[0][dp_idx]  <= input_data;
            end
            if (load_set_two) begin
                dp_valid[1][dp_idx] <= 1'b1;
                dp_dirty[1][dp_idx] <= write_type_set_two;
                dp_tag[1][dp_idx]   <= mem_address[15:7];
                dp_data[1][dp_idx]  <= input_data;
            end
        end
    end

    // ---------------- reference model ----------------
    bit           m_valid [2][8];
    bit           m_dirty [2][8];
    logic [8:0]   m_tag   [2][8];
    logic [127:0] m_data  [2][8];
    bit           m_lru   [8];
    logic [127:0] pmem_mem [logic [15:0]];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mem_line(input logic [15:0] a);
        logic [127:0] r;
        if (pmem_mem.exists(a)) begin
            r = pmem_mem[a];
        end else begin
            for (int j = 0; j < 4; j++) r[32*j +: 32] = ({16'h0, a} + 32'(j)) * 32'h9E3779B1;
        end
        return r;
    endfunction

    // Byte-addressed merge of a halfword into a line.
    function automatic logic [127:0] merge_ref(input logic [127:0] line, input logic [15:0] a,
                                               input logic [1:0] be, input logic [15:0] wd);
        logic [127:0] r;
        int lo;
        r  = line;
        lo = 8 * int'(a[3:0] & 4'hE);
        if (be[0]) r[lo +: 8] = wd[7:0];
        if (be[1]) r[lo + 8 +: 8] = wd[15:8];
        return r;
    endfunction

    task automatic clear_model();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 8; i++) begin
                m_valid[w][i] = 1'b0;
                m_dirty[w][i] = 1'b0;
                m_tag[w][i]   = 9'h000;
                m_data[w][i]  = 128'h0;
            end
        end
        for (int i = 0; i < 8; i++) m_lru[i] = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_ctl"}, {mem_resp, pmem_read, pmem_write, load_set_one, load_set_two,
                             write_type_set_one, write_type_set_two}, 128'h0);
        check({tag, "_indata"}, input_data, 128'h0);
        check({tag, "_paddr"}, {112'h0, pmem_address}, 128'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_model();
    endtask

    // One physical transaction lasting a random number of cycles.
    task automatic pmem_phase(input bit is_wr, input logic [15:0] exp_addr,
                              input logic [127:0] data, input int v, input bit drop);
        int lat;
        lat = int'($urandom_range(1, 4));
        for (int c = 1; c <= lat; c++) begin
            #1;
            check("pmem_rw", {pmem_read, pmem_write}, is_wr ? 2'b01 : 2'b10);
            check("pmem_addr", pmem_address, exp_addr);
            if (is_wr) check("pmem_wdata", pmem_wdata, data);
            check("busy_resp", mem_resp, 1'b0);
            check("busy_noload", {load_set_one, load_set_two}, 2'b00);
            if (drop) begin
                mem_read = 1'b0;
                mem_write = 1'b0;
            end
            if (c == lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = is_wr ? {4{$urandom}} : data;
                #1;
                if (is_wr) begin
                    check("wb_noload", {load_set_one, load_set_two}, 2'b00);
                end else begin
                    check("fill_load", {load_set_one, load_set_two}, (v == 0) ? 2'b10 : 2'b01);
                    check("fill_wtype", {write_type_set_one, write_type_set_two}, 2'b00);
                    check("fill_data", input_data, data);
                end
            end
            @(posedge clk);
            #1 pmem_resp = 1'b0;
        end
    endtask

    // Full CPU access: predicted miss handling, then the hit cycle.
    task automatic access(input logic [15:0] addr, input logic rd, input logic wr,
                          input logic [1:0] be, input logic [15:0] wd, input bit drop);
        logic [2:0]   idx;
        logic [8:0]   tg;
        logic [15:0]  wba;
        logic [127:0] line, exp_in;
        int hw, v;
        bit wb;
        idx = addr[6:4];
        tg  = addr[15:7];
        hw  = -1;
        for (int w = 0; w < 2; w++) if (m_valid[w][idx] && m_tag[w][idx] == tg) hw = w;
        mem_address = addr; mem_read = rd; mem_write = wr;
        mem_byte_enable = be; mem_wdata = wd;
        if (hw < 0) begin
            v  = !m_valid[0][idx] ? 0 : (!m_valid[1][idx] ? 1 : int'(m_lru[idx]));
            wb = m_valid[v][idx] && m_dirty[v][idx];
            #1;
            check("miss_resp", mem_resp, 1'b0);
            check("miss_noload", {load_set_one, load_set_two}, 2'b00);
            check("miss_nopmem", {pmem_read, pmem_write}, 2'b00);
            @(posedge clk);
            #1;
            if (wb) begin
                wba = {m_tag[v][idx], idx, 4'h0};
                pmem_phase(1'b1, wba, m_data[v][idx], v, 1'b0);
                pmem_mem[wba] = m_data[v][idx];
            end
            line = mem_line({addr[15:4], 4'h0});
            pmem_phase(1'b0, {addr[15:4], 4'h0}, line, v, drop);
            m_valid[v][idx] = 1'b1;
            m_dirty[v][idx] = 1'b0;
            m_tag[v][idx]   = tg;
            m_data[v][idx]  = line;
            hw = v;
        end
        if (drop) begin
            #1 idle_check("dropped");
            @(posedge clk);
            #1;
        end else begin
            exp_in = wr ? merge_ref(m_data[hw][idx], addr, be, wd) : 128'h0;
            #1;
            check("hit_resp", mem_resp, 1'b1);
            check("hit_nopmem", {pmem_read, pmem_write}, 2'b00);
            check("hit_load", {load_set_one, load_set_two},
                  {wr && (hw == 0), wr && (hw == 1)});
            check("hit_wtype", {write_type_set_one, write_type_set_two},
                  {wr && (hw == 0), wr && (hw == 1)});
            if (wr) check("hit_data", input_data, exp_in);
            @(posedge clk);
            #1;
            m_lru[idx] = (hw == 0);
            if (wr) begin
                m_data[hw][idx]  = exp_in;
                m_dirty[hw][idx] = 1'b1;
            end
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        int op;
        mem_address = 16'h0000; mem_byte_enable = 2'b00; mem_wdata = 16'h0000;
        pmem_rdata = 128'h0;
        do_reset();
        #1 idle_check("reset");

        // Responses while idle are ignored.
        pmem_resp = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 idle_check("idle_presp");
        end
        pmem_resp = 1'b0;

        // Fill both ways of index 0, hit both, write-merge, then dirty eviction.
        access(16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        access(16'h0080, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        access(16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        access(16'h0080, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        access(16'h0006, 1'b0, 1'b1, 2'b11, 16'h1234, 1'b0);
        check("merge_w3", m_data[0][0][63:48], 128'h1234);
        access(16'h0006, 1'b0, 1'b1, 2'b01, 16'hABCD, 1'b0);
        check("merge_lo", m_data[0][0][63:48], 128'h12CD);
        access(16'h0008, 1'b0, 1'b1, 2'b00, 16'hFFFF, 1'b0);
        access(16'h0080, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        access(16'h0100, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);

        // Reset during a writeback with a pending response.
        do_reset();
        access(16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        access(16'h0080, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        access(16'h0006, 1'b1, 1'b1, 2'b11, 16'h5555, 1'b0);
        access(16'h0080, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        mem_address = 16'h0100; mem_read = 1'b1;
        @(posedge clk);
        #1 check("rst_in_wb", pmem_write, 1'b1);
        reset = 1'b1; pmem_resp = 1'b1; mem_read = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0; pmem_resp = 1'b0;
        clear_model();
        #1 idle_check("after_rst");
        access(16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);

        // CPU drops its request during a fill.
        access(16'h0230, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b1);
        access(16'h0230, 1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);

        // Random traffic over a few tags per index.
        for (int n = 0; n < 400; n++) begin
            a  = {7'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 6'h0};
            a  = {a[15:7], a[12:10], 3'($urandom_range(0, 7)), 1'b0};
            op = int'($urandom_range(0, 3));
            access(a, op != 2, op >= 2, 2'($urandom_range(0, 3)), 16'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
